em_pipe_latch: RTL and testbench

Execute-to-memory pipeline register that consumes the per-latch state command from the hazard unit: PIPE_ENABLE loads, PIPE_STALL holds, PIPE_NOP inserts a bubble. It owns the data-memory request handshake for the instruction it holds. It drives dREN/dWEN until the first dhit, then masks the request so a held load or store is never re-issued. It also captures load data and keeps saturating stall and bubble counters for performance debug.

---
 rtl/em_pipe_latch.sv | 218 +++++++++++++++++++++
 tb/tb_em_pipe_latch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/em_pipe_latch.sv
// em_pipe_latch: execute-to-memory pipeline register.
//
// Holds one instruction between execute and memory under control of the hazard
// unit's per-latch command (load / hold / bubble). It also owns the data-memory
// handshake for the held instruction. The request is driven until the first dhit
// and then masked, so a held load or store is never re-issued. Load data is
// captured on that dhit. Saturating stall and bubble counters support
// performance debug.
//
// Ports:
//   CLK, nRST             clock (rising edge), asynchronous active-low reset
//   em_state              latch command: 00 enable, 01 stall, 10 nop, 11 = stall
//   ex_*                  instruction fields arriving from execute
//   dhit, dload           data memory completion and read data
//   mem_*                 registered instruction fields toward memory/writeback
//   dREN, dWEN            data memory read/write requests (registers only)
//   daddr, dstore         data memory address and store data
//   mem_dload             captured load data
//   mem_valid             latch holds a real instruction
//   mem_done              memory access of the held instruction has completed
//   stall_cnt, nop_cnt    saturating stall-cycle and bubble counters

module em_pipe_latch #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [1:0]    em_state,
    input  logic [31:0]   ex_instr,
    input  logic [DW-1:0] ex_npc,
    input  logic [DW-1:0] ex_alu_out,
    input  logic [DW-1:0] ex_store_data,
    input  logic [4:0]    ex_wsel,
    input  logic          ex_regwen,
    input  logic          ex_dREN,
    input  logic          ex_dWEN,
    input  logic          ex_halt,
    input  logic          dhit,
    input  logic [DW-1:0] dload,
    output logic [31:0]   mem_instr,
    output logic [DW-1:0] mem_npc,
    output logic [DW-1:0] mem_alu_out,
    output logic [DW-1:0] mem_store_data,
    output logic [4:0]    mem_wsel,
    output logic          mem_regwen,
    output logic          mem_halt,
    output logic          dREN,
    output logic          dWEN,
    output logic [DW-1:0] daddr,
    output logic [DW-1:0] dstore,
    output logic [DW-1:0] mem_dload,
    output logic          mem_valid,
    output logic          mem_done,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] nop_cnt
);

    typedef enum logic [1:0] {
        PipeEnable = 2'b00,
        PipeStall  = 2'b01,
        PipeNop    = 2'b10,
        PipeRsvd   = 2'b11
    } em_cmd_e;

    em_cmd_e cmd;
    assign cmd = em_cmd_e'(em_state);

    // Instruction fields
    logic [31:0]   instr_q, instr_d;
    logic [DW-1:0] npc_q, npc_d;
    logic [DW-1:0] alu_out_q, alu_out_d;
    logic [DW-1:0] store_data_q, store_data_d;
    logic [4:0]    wsel_q, wsel_d;
    logic          regwen_q, regwen_d;
    logic          halt_q, halt_d;
    logic          dren_q, dren_d;
    logic          dwen_q, dwen_d;

    // Handshake and status
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [DW-1:0] dload_q, dload_d;

    // Performance counters
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] nop_cnt_q, nop_cnt_d;

    logic outstanding;
    logic mem_hit;
    logic stall_sat;
    logic nop_sat;

    // A dhit only counts when the held instruction still has a live request.
    assign outstanding = (dren_q | dwen_q) & ~done_q;
    assign mem_hit     = dhit & outstanding;
    assign stall_sat   = &stall_cnt_q;
    assign nop_sat     = &nop_cnt_q;

    always_comb begin
        instr_d      = instr_q;
        npc_d        = npc_q;
        alu_out_d    = alu_out_q;
        store_data_d = store_data_q;
        wsel_d       = wsel_q;
        regwen_d     = regwen_q;
        halt_d       = halt_q;
        dren_d       = dren_q;
        dwen_d       = dwen_q;
        valid_d      = valid_q;
        done_d       = done_q;
        dload_d      = dload_q;
        stall_cnt_d  = stall_cnt_q;
        nop_cnt_d    = nop_cnt_q;

        unique case (cmd)
            PipeEnable: begin
                instr_d      = ex_instr;
                npc_d        = ex_npc;
                alu_out_d    = ex_alu_out;
                store_data_d = ex_store_data;
                wsel_d       = ex_wsel;
                regwen_d     = ex_regwen;
                halt_d       = ex_halt;
                dren_d       = ex_dREN;
                dwen_d       = ex_dWEN;
                valid_d      = 1'b1;
                done_d       = 1'b0;
                // The outgoing load may complete on the same edge it is replaced;
                // its data is still handed forward with the new instruction.
                dload_d      = (mem_hit & dren_q) ? dload : '0;
            end
            PipeNop: begin
                // Bubble wins over any concurrent dhit; a pending request drops.
                instr_d      = '0;
                npc_d        = '0;
                alu_out_d    = '0;
                store_data_d = '0;
                wsel_d       = '0;
                regwen_d     = 1'b0;
                halt_d       = 1'b0;
                dren_d       = 1'b0;
                dwen_d       = 1'b0;
                valid_d      = 1'b0;
                done_d       = 1'b0;
                dload_d      = '0;
                if (!nop_sat) begin
                    nop_cnt_d = nop_cnt_q + CW'(1);
                end
            end
            PipeStall, PipeRsvd: begin
                if (!stall_sat) begin
                    stall_cnt_d = stall_cnt_q + CW'(1);
                end
                if (mem_hit) begin
                    done_d = 1'b1;
                    if (dren_q) begin
                        dload_d = dload;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_q      <= '0;
            npc_q        <= '0;
            alu_out_q    <= '0;
            store_data_q <= '0;
            wsel_q       <= '0;
            regwen_q     <= 1'b0;
            halt_q       <= 1'b0;
            dren_q       <= 1'b0;
            dwen_q       <= 1'b0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            dload_q      <= '0;
            stall_cnt_q  <= '0;
            nop_cnt_q    <= '0;
        end else begin
            instr_q      <= instr_d;
            npc_q        <= npc_d;
            alu_out_q    <= alu_out_d;
            store_data_q <= store_data_d;
            wsel_q       <= wsel_d;
            regwen_q     <= regwen_d;
            halt_q       <= halt_d;
            dren_q       <= dren_d;
            dwen_q       <= dwen_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            dload_q      <= dload_d;
            stall_cnt_q  <= stall_cnt_d;
            nop_cnt_q    <= nop_cnt_d;
        end
    end

    // Outputs come straight from registers: no path from em_state or dhit.
    assign mem_instr      = instr_q;
    assign mem_npc        = npc_q;
    assign mem_alu_out    = alu_out_q;
    assign mem_store_data = store_data_q;
    assign mem_wsel       = wsel_q;
    assign mem_regwen     = regwen_q;
    assign mem_halt       = halt_q;
    assign dREN           = dren_q & ~done_q;
    assign dWEN           = dwen_q & ~done_q;
    assign daddr          = alu_out_q;
    assign dstore         = store_data_q;
    assign mem_dload      = dload_q;
    assign mem_valid      = valid_q;
    assign mem_done       = done_q;
    assign stall_cnt      = stall_cnt_q;
    assign nop_cnt        = nop_cnt_q;

endmodule

// File: tb/tb_em_pipe_latch.sv
// Self-checking bench for em_pipe_latch (DW=32, CW=4 so saturation is reachable).
module tb_em_pipe_latch;

    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    localparam logic [1:0] ENA = 2'b00;
    localparam logic [1:0] STL = 2'b01;
    localparam logic [1:0] NOP = 2'b10;
    localparam logic [1:0] RSV = 2'b11;

    logic          CLK;
    logic          nRST;
    logic [1:0]    em_state;
    logic [31:0]   ex_instr;
    logic [DW-1:0] ex_npc, ex_alu_out, ex_store_data;
    logic [4:0]    ex_wsel;
    logic          ex_regwen, ex_dREN, ex_dWEN, ex_halt;
    logic          dhit;
    logic [DW-1:0] dload;
    logic [31:0]   mem_instr;
    logic [DW-1:0] mem_npc, mem_alu_out, mem_store_data;
    logic [4:0]    mem_wsel;
    logic          mem_regwen, mem_halt;
    logic          dREN, dWEN;
    logic [DW-1:0] daddr, dstore, mem_dload;
    logic          mem_valid, mem_done;
    logic [CW-1:0] stall_cnt, nop_cnt;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    em_pipe_latch #(.DW(DW), .CW(CW)) dut (
        .CLK(CLK), .nRST(nRST), .em_state(em_state),
        .ex_instr(ex_instr), .ex_npc(ex_npc), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_wsel(ex_wsel), .ex_regwen(ex_regwen),
        .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_halt(ex_halt),
        .dhit(dhit), .dload(dload),
        .mem_instr(mem_instr), .mem_npc(mem_npc), .mem_alu_out(mem_alu_out),
        .mem_store_data(mem_store_data), .mem_wsel(mem_wsel), .mem_regwen(mem_regwen),
        .mem_halt(mem_halt), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .mem_dload(mem_dload), .mem_valid(mem_valid), .mem_done(mem_done),
        .stall_cnt(stall_cnt), .nop_cnt(nop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: what the latch holds, whether its memory op is finished,
    // and plain integer counters clipped at CMAX.
    typedef struct packed {
        logic [31:0] instr, npc, alu, sd;
        logic [4:0]  wsel;
        logic        regwen, halt, rd, wr, valid, done;
        logic [31:0] dl;
        logic [31:0] scnt, ncnt;
    } model_t;

    model_t m;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    function automatic model_t model_next(input model_t c);
        model_t n;
        logic   waiting;
        n = c;
        waiting = (c.rd || c.wr) && !c.done;
        if (em_state == ENA) begin
            n.instr = ex_instr; n.npc = ex_npc; n.alu = ex_alu_out; n.sd = ex_store_data;
            n.wsel = ex_wsel; n.regwen = ex_regwen; n.halt = ex_halt;
            n.rd = ex_dREN; n.wr = ex_dWEN; n.valid = 1'b1; n.done = 1'b0;
            n.dl = (dhit && waiting && c.rd) ? dload : 32'h0;
        end else if (em_state == NOP) begin
            n = '0;
            n.scnt = c.scnt;
            n.ncnt = sat_inc(c.ncnt);
        end else begin
            n.scnt = sat_inc(c.scnt);
            if (dhit && waiting) begin
                n.done = 1'b1;
                if (c.rd) n.dl = dload;
            end
        end
        return n;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) m <= '0;
        else       m <= model_next(m);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: every negedge, all outputs against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("mem_instr", mem_instr, m.instr);
            chk("mem_npc", mem_npc, m.npc);
            chk("mem_alu_out", mem_alu_out, m.alu);
            chk("mem_store_data", mem_store_data, m.sd);
            chk("mem_wsel", 32'(mem_wsel), 32'(m.wsel));
            chk("mem_regwen", 32'(mem_regwen), 32'(m.regwen));
            chk("mem_halt", 32'(mem_halt), 32'(m.halt));
            chk("dREN", 32'(dREN), 32'(m.rd & ~m.done));
            chk("dWEN", 32'(dWEN), 32'(m.wr & ~m.done));
            chk("daddr", daddr, m.alu);
            chk("dstore", dstore, m.sd);
            chk("mem_dload", mem_dload, m.dl);
            chk("mem_valid", 32'(mem_valid), 32'(m.valid));
            chk("mem_done", 32'(mem_done), 32'(m.done));
            chk("stall_cnt", 32'(stall_cnt), m.scnt);
            chk("nop_cnt", 32'(nop_cnt), m.ncnt);
        end
    end

    task automatic set_ex(input logic [31:0] instr, input logic [31:0] alu,
                          input logic [31:0] sd, input logic rd, input logic wr);
        ex_instr = instr; ex_npc = alu + 32'h1000; ex_alu_out = alu; ex_store_data = sd;
        ex_wsel = instr[20:16]; ex_regwen = rd | ~wr; ex_halt = 1'b0;
        ex_dREN = rd; ex_dWEN = wr;
    endtask

    // Inputs change just after a negedge; outputs are sampled at the next negedge.
    task automatic cyc(input logic [1:0] st, input logic hit, input logic [31:0] dl);
        em_state = st; dhit = hit; dload = dl;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 1'b0; em_state = STL; dhit = 1'b0; dload = '0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0; em_state = STL; dhit = 1'b0; dload = '0;
        set_ex(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        do_reset();
        cmp_en = 1'b1;
        chk("reset dREN", 32'(dREN), 32'h0);
        chk("reset mem_valid", 32'(mem_valid), 32'h0);
        chk("reset stall_cnt", 32'(stall_cnt), 32'h0);

        // Load with dhit in the second stall
        set_ex(32'h8C01_0000, 32'h100, 32'h0, 1'b1, 1'b0);
        cyc(ENA, 1'b0, 32'h0);
        chk("t1 dREN after enable", 32'(dREN), 32'h1);
        chk("t1 daddr", daddr, 32'h100);
        cyc(STL, 1'b0, 32'h0);
        chk("t1 dREN stall1", 32'(dREN), 32'h1);
        cyc(STL, 1'b1, 32'hDEAD_BEEF);
        chk("t1 dREN after hit", 32'(dREN), 32'h0);
        chk("t1 mem_done", 32'(mem_done), 32'h1);
        cyc(STL, 1'b0, 32'h0);
        chk("t1 mem_dload", mem_dload, 32'hDEAD_BEEF);
        chk("t1 stall_cnt", 32'(stall_cnt), 32'h3);

        // Store held across five stalls with no dhit
        do_reset();
        set_ex(32'hAC01_0000, 32'h200, 32'h55, 1'b0, 1'b1);
        cyc(ENA, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(STL, 1'b0, 32'h0);
            chk("t2 dWEN held", 32'(dWEN), 32'h1);
            chk("t2 dstore", dstore, 32'h55);
        end
        chk("t2 stall_cnt", 32'(stall_cnt), 32'h5);
        chk("t2 mem_done", 32'(mem_done), 32'h0);

        // NOP with coincident dhit over a pending load
        do_reset();
        set_ex(32'h8C02_0000, 32'h300, 32'h0, 1'b1, 1'b0);
        cyc(ENA, 1'b0, 32'h0);
        cyc(NOP, 1'b1, 32'h1234_5678);
        chk("t3 mem_instr", mem_instr, 32'h0);
        chk("t3 mem_valid", 32'(mem_valid), 32'h0);
        chk("t3 dREN", 32'(dREN), 32'h0);
        chk("t3 mem_dload", mem_dload, 32'h0);
        chk("t3 nop_cnt", 32'(nop_cnt), 32'h1);

        // Load completes on the edge a store is enabled
        do_reset();
        set_ex(32'h8C03_0000, 32'h400, 32'h0, 1'b1, 1'b0);
        cyc(ENA, 1'b0, 32'h0);
        cyc(STL, 1'b0, 32'h0);
        set_ex(32'hAC04_0000, 32'h404, 32'h77, 1'b0, 1'b1);
        cyc(ENA, 1'b1, 32'hCAFE_F00D);
        chk("t4 mem_dload", mem_dload, 32'hCAFE_F00D);
        chk("t4 dWEN", 32'(dWEN), 32'h1);
        chk("t4 mem_done", 32'(mem_done), 32'h0);

        // Counter saturation, then asynchronous reset mid-stall
        do_reset();
        set_ex(32'h8C05_0000, 32'h500, 32'h0, 1'b1, 1'b0);
        cyc(ENA, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) cyc(STL, 1'b0, 32'h0);
        chk("t5 stall_cnt saturated", 32'(stall_cnt), 32'hF);
        chk("t5 dREN before reset", 32'(dREN), 32'h1);
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("t5 async stall_cnt", 32'(stall_cnt), 32'h0);
        chk("t5 async dREN", 32'(dREN), 32'h0);
        chk("t5 async mem_valid", 32'(mem_valid), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Reserved command behaves as stall on a non-memory instruction
        do_reset();
        set_ex(32'h0022_1820, 32'h42, 32'h9, 1'b0, 1'b0);
        cyc(ENA, 1'b0, 32'h0);
        cyc(RSV, 1'b1, 32'hFFFF_FFFF);
        cyc(RSV, 1'b0, 32'h0);
        chk("t6 stall_cnt", 32'(stall_cnt), 32'h2);
        chk("t6 mem_alu_out", mem_alu_out, 32'h42);
        chk("t6 mem_valid", 32'(mem_valid), 32'h1);
        chk("t6 mem_done", 32'(mem_done), 32'h0);
        chk("t6 mem_dload", mem_dload, 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            logic [1:0] st;
            r = $urandom_range(0, 9);
            st = (r < 4) ? ENA : (r < 8) ? STL : (r == 8) ? NOP : RSV;
            ex_instr = $urandom; ex_npc = $urandom; ex_alu_out = $urandom;
            ex_store_data = $urandom; ex_wsel = 5'($urandom); ex_regwen = 1'($urandom);
            ex_halt = ($urandom_range(0, 15) == 0);
            ex_dREN = 1'($urandom); ex_dWEN = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 nRST = 1'b0;
                #2 nRST = 1'b1;
            end
            cyc(st, ($urandom_range(0, 2) == 0), $urandom);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
